bist_controller: RTL and testbench



---
 rtl/bist_pkg.sv | 23 ++
 rtl/bist_controller_if.sv | 23 ++
 rtl/bist_misr.sv | 23 ++
 rtl/bist_controller.sv | 89 ++++++++
 tb/tb_bist_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types, widths and LFSR step for the BIST sequencer
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    COMPARE,
    DONE
  } bist_state_t;

  localparam int LFSR_W = 5;
  localparam int MISR_W = 8;
  localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;
  localparam int LFSR_TAP_A = 4;
  localparam int LFSR_TAP_B = 2;

  // XNOR feedback keeps all-zeros legal; all-ones is the lockup state.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ~(cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B])};
  endfunction

endpackage

// File: rtl/bist_controller_if.sv
// rtl/bist_controller_if.sv - run control and result bundle between test access logic and BIST
interface bist_controller_if;
  import bist_pkg::*;

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;
  logic [LFSR_W-1:0] pattern_count;

  modport master (
    output start, abort,
    input  busy, done, pass, signature, pattern_count
  );

  modport slave (
    input  start, abort,
    output busy, done, pass, signature, pattern_count
  );

endinterface

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - 8-bit multiple-input signature register compacting the 2-bit CUT response
module bist_misr
  import bist_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [1:0]        data,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], 1'b0}
           ^ (sig[MISR_W-1] ? MISR_POLY : '0)
           ^ {{(MISR_W-2){1'b0}}, data};
    end
  end

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - BIST sequencer: seeds the LFSR, applies patterns to the CUT, checks the MISR signature
module bist_controller
  import bist_pkg::*;
#(
  parameter int                NUM_PATTERNS = 31,
  parameter logic [LFSR_W-1:0] SEED         = 5'b00000,
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  bist_controller_if.slave   bus,
  input  logic [1:0]         cut_resp,
  output logic [LFSR_W-1:0]  test_vec
);

  localparam logic [LFSR_W-1:0] PAT_LAST = LFSR_W'(NUM_PATTERNS - 1);
  localparam logic [LFSR_W-1:0] PAT_MAX  = LFSR_W'(NUM_PATTERNS);

  bist_state_t       state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] count;
  logic              pass_q;
  logic [MISR_W-1:0] sig;
  logic              in_run;
  logic              misr_clear;
  logic              misr_en;

  assign in_run = (state == LOAD) || (state == APPLY) || (state == COMPARE);

  // An abort freezes the signature, so the MISR must not clear or shift on that cycle.
  assign misr_clear = (state == LOAD)  && !bus.abort;
  assign misr_en    = (state == APPLY) && !bus.abort;

  bist_misr u_misr (
    .clk   (clk),
    .reset (reset),
    .clear (misr_clear),
    .en    (misr_en),
    .data  (cut_resp),
    .sig   (sig)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lfsr   <= SEED;
      count  <= '0;
      pass_q <= 1'b0;
    end else if (bus.abort && in_run) begin
      state  <= IDLE;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state <= LOAD;
        end
        LOAD: begin
          lfsr   <= SEED;
          count  <= '0;
          pass_q <= 1'b0;
          state  <= APPLY;
        end
        APPLY: begin
          lfsr <= lfsr_next(lfsr);
          if (count != PAT_MAX) count <= count + 1'b1;
          if (count == PAT_LAST) state <= COMPARE;
        end
        COMPARE: begin
          pass_q <= (sig == GOLDEN_SIG);
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign test_vec          = lfsr;
  assign bus.busy          = in_run;
  assign bus.done          = (state == DONE);
  assign bus.pass          = pass_q;
  assign bus.signature     = sig;
  assign bus.pattern_count = count;

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - directed and randomized checks of bist_controller against a behavioural model
module tb_bist_controller;

  // c17 benchmark: test_vec = {N7,N6,N3,N2,N1}, response = {N23,N22}
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;
    n1 = v[0]; n2 = v[1]; n3 = v[2]; n6 = v[3]; n7 = v[4];
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    n22 = ~(n10 & n16);
    n23 = ~(n16 & n19);
    return {n23, n22};
  endfunction

  function automatic int lfsr_succ(input int l);
    int fb;
    fb = (((l >> 4) & 1) == ((l >> 2) & 1)) ? 1 : 0;
    return ((l * 2) % 32) + fb;
  endfunction

  function automatic int misr_succ(input int m, input int r);
    int s;
    s = (m * 2) % 256;
    if (m >= 128) s = s ^ 'h1D;
    return s ^ r;
  endfunction

  function automatic int c17_signature(input int stuck_n22);
    int l, m, r;
    l = 0;
    m = 0;
    for (int k = 0; k < 31; k++) begin
      r = int'(c17(5'(l)));
      if (stuck_n22 != 0) r = r & 2;
      m = misr_succ(m, r);
      l = lfsr_succ(l);
    end
    return m;
  endfunction

  localparam logic [7:0] C17_GOLD = 8'(c17_signature(0));

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [1:0] cut_resp;
  logic [1:0] cut_z;
  logic [4:0] tv;
  logic [4:0] tv_z;
  logic [1:0] rand_resp;
  int         mode;
  int         cyc = 0;
  int         done_seen = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done) done_seen <= done_seen + 1;

  bist_controller_if bus ();
  bist_controller_if bus_z ();

  assign bus.start   = start;
  assign bus.abort   = abort;
  assign bus_z.start = start;
  assign bus_z.abort = abort;
  assign cut_z       = 2'b00;
  assign cut_resp    = (mode == 1) ? c17(tv)
                     : (mode == 2) ? (c17(tv) & 2'b10)
                     : (mode == 3) ? rand_resp
                     : 2'b00;

  bist_controller #(.NUM_PATTERNS(31), .SEED(5'b00000), .GOLDEN_SIG(C17_GOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cut_resp (cut_resp),
    .test_vec (tv)
  );

  bist_controller #(.NUM_PATTERNS(31), .SEED(5'b00000), .GOLDEN_SIG(8'h00)) dut_z (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_z),
    .cut_resp (cut_z),
    .test_vec (tv_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tv"},    32'(tv), 32'h0);
    chk({tag, "_busy"},  32'(bus.busy), 32'h0);
    chk({tag, "_done"},  32'(bus.done), 32'h0);
    chk({tag, "_pass"},  32'(bus.pass), 32'h0);
    chk({tag, "_sig"},   32'(bus.signature), 32'h0);
    chk({tag, "_count"}, 32'(bus.pattern_count), 32'h0);
  endtask

  // Called at a negedge with the DUT idle; abort_at < 0 means run to completion.
  task automatic run(input int m, input int abort_at, input bit rand_start);
    int l, s, r, t0, d0;
    mode = m;
    l = 0;
    s = 0;
    d0 = done_seen;
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    for (int k = 0; k < 31; k++) begin
      chk($sformatf("tv_m%0d_k%0d", m, k), 32'(tv), 32'(l));
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",   32'(bus.busy), 32'h0);
        chk("abort_pass",   32'(bus.pass), 32'h0);
        chk("abort_count",  32'(bus.pattern_count), 32'(k));
        chk("abort_sig",    32'(bus.signature), 32'(s));
        chk("abort_nodone", 32'(done_seen - d0), 32'h0);
        @(negedge clk);
        chk("abort_still_idle", 32'(bus.busy), 32'h0);
        return;
      end
      rand_resp = 2'($urandom);
      if (rand_start) start = 1'($urandom);
      case (m)
        1:       r = int'(c17(5'(l)));
        2:       r = int'(c17(5'(l))) & 2;
        3:       r = int'(rand_resp);
        default: r = 0;
      endcase
      s = misr_succ(s, r);
      l = lfsr_succ(l);
      @(negedge clk);
      start = 1'b0;
    end
    chk("cmp_busy", 32'(bus.busy), 32'h1);
    chk("cmp_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    chk("done_pulse",   32'(bus.done), 32'h1);
    chk("done_latency", 32'(cyc - t0), 32'd34);
    chk("done_busy",    32'(bus.busy), 32'h0);
    chk("done_sig",     32'(bus.signature), 32'(s));
    chk("done_pass",    32'(bus.pass), 32'((s == int'(C17_GOLD)) ? 1 : 0));
    chk("done_count",   32'(bus.pattern_count), 32'd31);
    chk("done_once",    32'(done_seen - d0), 32'h0);
    chk("z_done",       32'(bus_z.done), 32'h1);
    chk("z_pass",       32'(bus_z.pass), 32'h1);
    chk("z_sig",        32'(bus_z.signature), 32'h0);
    if (m == 2) chk("stuck_sig_differs", 32'(bus.signature != C17_GOLD), 32'h1);
    repeat (3) @(negedge clk);
    chk("idle_done",  32'(bus.done), 32'h0);
    chk("hold_sig",   32'(bus.signature), 32'(s));
    chk("hold_pass",  32'(bus.pass), 32'((s == int'(C17_GOLD)) ? 1 : 0));
    chk("hold_count", 32'(bus.pattern_count), 32'd31);
    chk("hold_tv",    32'(tv), 32'(l));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, c1, c2;
    logic [7:0] s1, s2;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode = 0;
    rand_resp = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_values("rst");

    run(0, -1, 1'b0);
    run(1, -1, 1'b0);
    run(2, -1, 1'b0);
    run(1, 10, 1'b0);
    run(1, -1, 1'b0);
    run(3, -1, 1'b1);
    run(3, int'($urandom_range(0, 30)), 1'b0);
    run(1, -1, 1'b1);

    // reset in the middle of APPLY
    mode = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_values("midrst");

    // start held high: back-to-back runs
    mode = 1;
    start = 1'b1;
    w = 0;
    while (!bus.done && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("b2b_done1", 32'(bus.done), 32'h1);
    c1 = cyc;
    s1 = bus.signature;
    @(negedge clk);
    w = 0;
    while (!bus.done && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("b2b_done2", 32'(bus.done), 32'h1);
    c2 = cyc;
    s2 = bus.signature;
    start = 1'b0;
    chk("b2b_spacing", 32'(c2 - c1), 32'd35);
    chk("b2b_sig1", 32'(s1), 32'(C17_GOLD));
    chk("b2b_sig2", 32'(s2), 32'(C17_GOLD));
    chk("b2b_pass", 32'(bus.pass), 32'h1);
    repeat (3) @(negedge clk);
    chk("b2b_idle", 32'(bus.busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
